// File: rtl/fpm_bus_driver.sv
// Bus-master sequencer for the memory-mapped FP multiplier: writes A, B and GO,
// polls status until DONE (or timeout), reads the product and returns it on a response port.
module fpm_bus_driver #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_p_o,
  output logic [5:0]  rsp_flags_o,
  output logic        rsp_timeout_o,
  output logic [1:0]  a_o,
  output logic [31:0] wd_o,
  output logic        we_o,
  input  logic [31:0] rd_i
);

  localparam logic [1:0]       ADDR_A    = 2'd0;
  localparam logic [1:0]       ADDR_B    = 2'd1;
  localparam logic [1:0]       ADDR_P    = 2'd2;
  localparam logic [1:0]       ADDR_CTRL = 2'd3;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, WR_GO, POLL, RD_P, RESP
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       op_b_q, op_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       p_q, p_d;
  logic [5:0]        flags_q, flags_d;
  logic              timeout_q, timeout_d;
  logic [1:0]        a_q, a_d;
  logic [31:0]       wd_q, wd_d;
  logic              we_q, we_d;

  // Bus signals are registered: a_d/wd_d/we_d describe the cycle of the state being entered,
  // so the bus is glitch-free and aligned with state_q.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    if (rst) begin
      state_q   <= IDLE;
      op_b_q    <= '0;
      cnt_q     <= '0;
      p_q       <= '0;
      flags_q   <= '0;
      timeout_q <= 1'b0;
      a_q       <= ADDR_A;
      wd_q      <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_b_q    <= op_b_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      flags_q   <= flags_d;
      timeout_q <= timeout_d;
      a_q       <= a_d;
      wd_q      <= wd_d;
      we_q      <= we_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    state_d   = state_q;
    op_b_d    = op_b_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    flags_d   = flags_q;
    timeout_d = timeout_q;
    a_d       = a_q;
    wd_d      = '0;
    we_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_b_d    = req_b_i;
          p_d       = '0;
          flags_d   = '0;
          timeout_d = 1'b0;
          a_d       = ADDR_A;
          wd_d      = req_a_i;
          we_d      = 1'b1;
          state_d   = WR_A;
        end
      end
      WR_A: begin
        a_d     = ADDR_B;
        wd_d    = op_b_q;
        we_d    = 1'b1;
        state_d = WR_B;
      end
      WR_B: begin
        a_d     = ADDR_CTRL;
        wd_d    = 32'h1;
        we_d    = 1'b1;
        cnt_d   = '0;
        state_d = WR_GO;
      end
      WR_GO: begin
        a_d     = ADDR_CTRL;
        state_d = POLL;
      end
      POLL: begin
        // DONE is checked before the limit so a DONE on the last allowed poll is still honoured.
        if (rd_i[0]) begin
          flags_d = rd_i[13:8];
          a_d     = ADDR_P;
          state_d = RD_P;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          p_d       = '0;
          flags_d   = '0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_P: begin
        p_d     = rd_i;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_p_o       = p_q;
  assign rsp_flags_o   = flags_q;
  assign rsp_timeout_o = timeout_q;
  assign a_o           = a_q;
  assign wd_o          = wd_q;
  assign we_o          = we_q;

endmodule

// File: tb/tb_fpm_bus_driver.sv
// Directed bench for fpm_bus_driver with a small behavioural model of the FP multiplier peripheral.
module tb_fpm_bus_driver;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_p;
  logic [5:0]  rsp_flags;
  logic        rsp_timeout;
  logic [1:0]  a;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpm_bus_driver #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_p_o      (rsp_p),
    .rsp_flags_o  (rsp_flags),
    .rsp_timeout_o(rsp_timeout),
    .a_o          (a),
    .wd_o         (wd),
    .we_o         (we),
    .rd_i         (rd)
  );

  // Peripheral model: GO clears the DONE latch and starts a countdown of m_delay cycles
  // (0 = never done); DONE then stays set until the next GO.
  logic [31:0] m_a = '0, m_b = '0, m_p = '0;
  logic [5:0]  m_flags = '0;
  logic        m_done = 1'b0;
  int          m_cnt = 0;
  int          m_delay = 0;

  always @(posedge clk) begin
    if (we && a == 2'd0) m_a <= wd;
    if (we && a == 2'd1) m_b <= wd;
    if (we && a == 2'd3 && wd[0]) begin
      m_done <= 1'b0;
      m_cnt  <= m_delay;
    end else if (m_cnt > 0) begin
      if (m_cnt == 1) m_done <= 1'b1;
      m_cnt <= m_cnt - 1;
    end
  end

  assign rd = (a == 2'd0) ? m_a :
              (a == 2'd1) ? m_b :
              (a == 2'd2) ? m_p : {18'b0, m_flags, 7'b0, m_done};

  // Bus monitor, sampled mid-cycle.
  logic [1:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          poll_count = 0;
  int          rdp_count  = 0;
  logic        first_poll_done = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (we) begin
        wr_addr.push_back(a);
        wr_data.push_back(wd);
      end
      if (!we && a == 2'd3 && !rsp_valid && !req_ready) begin
        if (poll_count == 0) first_poll_done = rd[0];
        poll_count++;
      end
      if (!we && a == 2'd2 && !rsp_valid && !req_ready) rdp_count++;
    end
  end

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    poll_count = 0;
    rdp_count  = 0;
  endtask

  task automatic send_req(input logic [31:0] op_a, input logic [31:0] op_b);
    bit took = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = op_a;
    req_b     = op_b;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        took = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!took) begin
      failures++;
      $display("FAIL req_accept: req_ready=0 after 50 cycles, required 1");
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'hDEAD_BEEF;
  endtask

  task automatic wait_rsp();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rsp_wait: rsp_valid=0 after 200 cycles, required 1");
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_p, rsp_flags, rsp_timeout, a, wd, we} !==
        {1'b1, 1'b0, 32'h0, 6'h0, 1'b0, 2'd0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: rdy=%b vld=%b p=%h fl=%h to=%b a=%0d wd=%h we=%b, required 1 0 0 0 0 0 0 0",
               req_ready, rsp_valid, rsp_p, rsp_flags, rsp_timeout, a, wd, we);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    m_delay = 4; m_p = 32'h4000_0000; m_flags = 6'h00;
    clear_mon();
    send_req(32'h3F80_0000, 32'h4000_0000);
    wait_rsp();
    checks++;
    if (wr_addr.size() != 3) begin
      failures++;
      $display("FAIL basic_write_count: got %0d writes, required 3", wr_addr.size());
    end else begin
      checks++;
      if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]} !==
          {2'd0, 32'h3F80_0000, 2'd1, 32'h4000_0000, 2'd3, 32'h0000_0001}) begin
        failures++;
        $display("FAIL basic_writes: got %0d:%h %0d:%h %0d:%h, required 0:3f800000 1:40000000 3:00000001",
                 wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]);
      end
    end
    checks++;
    if ({rsp_p, rsp_flags, rsp_timeout} !== {32'h4000_0000, 6'h00, 1'b0}) begin
      failures++;
      $display("FAIL basic_rsp: p=%h flags=%h to=%b, required 40000000 00 0", rsp_p, rsp_flags, rsp_timeout);
    end
    checks++;
    if (rdp_count != 1) begin
      failures++;
      $display("FAIL basic_rdp: product reads=%0d, required 1", rdp_count);
    end
    finish_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_release: vld=%b rdy=%b, required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_overflow();
    m_delay = 2; m_p = 32'h7F80_0000; m_flags = 6'b100100;
    clear_mon();
    send_req(32'h7F00_0000, 32'h7F00_0000);
    wait_rsp();
    checks++;
    if ({rsp_p, rsp_flags, rsp_timeout} !== {32'h7F80_0000, 6'b100100, 1'b0}) begin
      failures++;
      $display("FAIL ovf_rsp: p=%h flags=%b to=%b, required 7f800000 100100 0", rsp_p, rsp_flags, rsp_timeout);
    end
    finish_rsp();
  endtask

  task automatic test_timeout();
    m_delay = 0; m_p = 32'h1234_5678; m_flags = 6'h3F;
    clear_mon();
    send_req(32'h4040_0000, 32'h4080_0000);
    wait_rsp();
    checks++;
    if (poll_count != TIMEOUT) begin
      failures++;
      $display("FAIL tmo_polls: polls=%0d, required %0d", poll_count, TIMEOUT);
    end
    checks++;
    if ({rsp_p, rsp_flags, rsp_timeout} !== {32'h0, 6'h0, 1'b1} || rdp_count != 0) begin
      failures++;
      $display("FAIL tmo_rsp: p=%h flags=%h to=%b prd=%0d, required 0 0 1 0", rsp_p, rsp_flags, rsp_timeout, rdp_count);
    end
    finish_rsp();
  endtask

  // DONE first visible on poll 8 (the last allowed one) must still complete normally,
  // which also shows the previous timeout flag was cleared on accept.
  task automatic test_last_poll();
    m_delay = TIMEOUT - 1; m_p = 32'h4140_0000; m_flags = 6'h00;
    clear_mon();
    send_req(32'h4040_0000, 32'h4080_0000);
    wait_rsp();
    checks++;
    if ({rsp_p, rsp_flags, rsp_timeout} !== {32'h4140_0000, 6'h00, 1'b0} || poll_count != TIMEOUT) begin
      failures++;
      $display("FAIL last_poll: p=%h flags=%h to=%b polls=%0d, required 41400000 00 0 %0d",
               rsp_p, rsp_flags, rsp_timeout, poll_count, TIMEOUT);
    end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    logic [31:0] held;
    int          wr_before;
    bit          stable = 1'b1;
    m_delay = 1; m_p = 32'h40C0_0000; m_flags = 6'h00;
    clear_mon();
    send_req(32'h4000_0000, 32'h4040_0000);
    wait_rsp();
    held      = rsp_p;
    wr_before = wr_addr.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_p !== held || req_ready !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable || held !== 32'h40C0_0000 || wr_addr.size() != wr_before) begin
      failures++;
      $display("FAIL hold_stable: stable=%b p=%h new_writes=%0d, required 1 40c00000 0",
               stable, held, wr_addr.size() - wr_before);
    end
    m_p = 32'h4100_0000;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a     = 32'h4000_0000;
    req_b     = 32'h4080_0000;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle: vld=%b rdy=%b, required 0 1", rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || we !== 1'b1 || a !== 2'd0 || wd !== 32'h4000_0000) begin
      failures++;
      $display("FAIL b2b_accept: rdy=%b we=%b a=%0d wd=%h, required 0 1 0 40000000", req_ready, we, a, wd);
    end
    wait_rsp();
    checks++;
    if ({rsp_p, rsp_timeout} !== {32'h4100_0000, 1'b0}) begin
      failures++;
      $display("FAIL b2b_rsp: p=%h to=%b, required 41000000 0", rsp_p, rsp_timeout);
    end
    finish_rsp();
  endtask

  // Previous op leaves the model's DONE latch set; the new op must not see it.
  task automatic test_stale_done();
    m_delay = 3; m_p = 32'h4110_0000; m_flags = 6'h00;
    clear_mon();
    send_req(32'h4040_0000, 32'h4040_0000);
    wait_rsp();
    checks++;
    if (first_poll_done !== 1'b0 || rsp_p !== 32'h4110_0000 || poll_count != 4) begin
      failures++;
      $display("FAIL stale_done: first_poll_done=%b p=%h polls=%0d, required 0 41100000 4",
               first_poll_done, rsp_p, poll_count);
    end
    finish_rsp();
  endtask

  task automatic test_reset_in_poll();
    int wr_after;
    m_delay = 0;
    clear_mon();
    send_req(32'h3F80_0000, 32'h3F80_0000);
    for (int i = 0; i < 20 && poll_count < 2; i++) @(negedge clk);
    checks++;
    if (poll_count < 2) begin
      failures++;
      $display("FAIL rst_poll_reach: polls=%0d, required >=2", poll_count);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, we, a} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL rst_poll_state: rdy=%b vld=%b we=%b a=%0d, required 1 0 0 0", req_ready, rsp_valid, we, a);
    end
    wr_after = wr_addr.size();
    repeat (12) @(negedge clk);
    checks++;
    if (rdp_count != 0 || wr_addr.size() != wr_after || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_poll_quiet: prd=%0d new_writes=%0d vld=%b rdy=%b, required 0 0 0 1",
               rdp_count, wr_addr.size() - wr_after, rsp_valid, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_timeout();
    test_last_poll();
    test_back_to_back();
    test_stale_done();
    test_reset_in_poll();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

endmodule
